// File: rtl/serial_log_fpmul_pkg.sv
// Shared types, flag positions and format helpers for the serial
// logarithmic floating-point multiplier.
package serial_log_fpmul_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_e;

  // Bit positions inside flags = {nan, inf, zero, ovf_or_unf}
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OU   = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int n_beats(input int w, input int bus_w);
    return (w + bus_w - 1) / bus_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/log_fpmul_core.sv
// Combinational Mitchell multiplier: adds the biased exponent/mantissa
// fields as one fixed-point log value and resolves IEEE special cases.
module log_fpmul_core
  import serial_log_fpmul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int COMP  = 44
) (
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 mode,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = EXP_W + MAN_W + 2;
  localparam logic signed [SW-1:0] BIAS_SH = SW'(bias(EXP_W)) << MAN_W;
  localparam logic signed [SW-1:0] INF_TH  = SW'((1 << EXP_W) - 1) << MAN_W;
  localparam logic signed [SW-1:0] COMP_S  = SW'(COMP);
  localparam logic signed [SW-1:0] S_ZERO  = '0;
  localparam logic [63:0]          NAN_PAT = canon_nan(EXP_W, MAN_W);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic sign;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [SW-1:0] s;

  assign {ea, ma} = a[EXP_W+MAN_W-1:0];
  assign {eb, mb} = b[EXP_W+MAN_W-1:0];
  assign sign     = a[W-1] ^ b[W-1];

  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  // Subnormals flush to zero, so only the exponent matters here.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  always_comb begin
    result = '0;
    flags  = '0;
    s = $signed({2'b00, a[EXP_W+MAN_W-1:0]}) + $signed({2'b00, b[EXP_W+MAN_W-1:0]})
        - BIAS_SH + (mode ? COMP_S : S_ZERO);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      result          = NAN_PAT[W-1:0];
      flags[FLAG_NAN] = 1'b1;
    end else if (a_inf || b_inf) begin
      result          = {sign, EXP_ONES, {MAN_W{1'b0}}};
      flags[FLAG_INF] = 1'b1;
    end else if (a_zero || b_zero) begin
      result           = {sign, {(W-1){1'b0}}};
      flags[FLAG_ZERO] = 1'b1;
    end else if (s <= S_ZERO) begin
      result           = {sign, {(W-1){1'b0}}};
      flags[FLAG_ZERO] = 1'b1;
      flags[FLAG_OU]   = 1'b1;
    end else if (s >= INF_TH) begin
      result          = {sign, EXP_ONES, {MAN_W{1'b0}}};
      flags[FLAG_INF] = 1'b1;
      flags[FLAG_OU]  = 1'b1;
    end else begin
      result = {sign, s[EXP_W+MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/serial_log_fpmul.sv
// Beat-serial wrapper around log_fpmul_core: loads A/B LSB beat first,
// computes in one cycle, then streams the result back out.
//
// Handshake: a beat moves on any rising edge where valid and ready are
// both high; the producer holds data stable while valid is high and
// ready is low, and ready never depends combinationally on valid.
module serial_log_fpmul
  import serial_log_fpmul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8,
  parameter int COMP  = 44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] a_beat,
  input  logic [BUS_W-1:0] b_beat,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_beat,
  output logic             out_last,
  output logic [3:0]       flags,
  output logic [1:0]       dbg_state
);

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int N_BEATS = n_beats(W, BUS_W);
  localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int RW      = N_BEATS * BUS_W;
  localparam logic [CW-1:0] LAST = CW'(N_BEATS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q, b_q;
  logic            mode_q;
  logic [RW-1:0]   res_q;
  logic [3:0]      flags_q;
  logic [W-1:0]    core_res;
  logic [3:0]      core_flags;
  logic            in_fire, out_fire;

  log_fpmul_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .COMP  (COMP)
  ) u_core (
    .a      (a_q),
    .b      (b_q),
    .mode   (mode_q),
    .result (core_res),
    .flags  (core_flags)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt_q == LAST) state_d = CALC;
      end
      CALC: state_d = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && cnt_q == LAST) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (in_fire) begin
        // Only bits below W are kept; padding in the last beat is dropped.
        for (int i = 0; i < W; i++) begin
          if (i / BUS_W == int'(cnt_q)) begin
            a_q[i] <= a_beat[i % BUS_W];
            b_q[i] <= b_beat[i % BUS_W];
          end
        end
        if (cnt_q == '0) mode_q <= mode;
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      if (state_q == CALC) begin
        res_q   <= RW'(core_res);
        flags_q <= core_flags;
      end
      if (out_fire) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign out_beat  = (state_q == SEND) ? res_q[int'(cnt_q)*BUS_W +: BUS_W] : '0;
  assign out_last  = (state_q == SEND) && (cnt_q == LAST);
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule
